// File: rtl/control_sequencer_if.sv
// Handshake and strobe bundle between an instruction issuer and control_sequencer.
// master drives instruction/status inputs; slave is the sequencer producing datapath strobes.
interface control_sequencer_if #(
  parameter int unsigned CODE_W = 10
) ();

  logic              start;
  logic [CODE_W-1:0] CODE;
  logic              branch_taken;
  logic              mem_ready;
  logic              busy;
  logic              alu_sel_A;
  logic              alu_sel_B;
  logic              pc_load;
  logic              rf_we;
  logic              mem_rd;
  logic              mem_wr;
  logic              done;
  logic              illegal;
  logic              timeout;

  modport master (
    output start, CODE, branch_taken, mem_ready,
    input  busy, alu_sel_A, alu_sel_B, pc_load, rf_we, mem_rd, mem_wr, done, illegal, timeout
  );

  modport slave (
    input  start, CODE, branch_taken, mem_ready,
    output busy, alu_sel_A, alu_sel_B, pc_load, rf_we, mem_rd, mem_wr, done, illegal, timeout
  );

endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle instruction control sequencer: IDLE/DECODE/EXEC/MEM/WB/TRAP.
// Define CTRL_CSR_SUPPORT_EN to execute the CSR class; otherwise CSR traps as illegal.
module control_sequencer #(
  parameter int unsigned CODE_W   = 10,
  parameter int unsigned WAIT_W   = 4,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  control_sequencer_if.slave  bus
);

  localparam int unsigned BitJ    = 0;
  localparam int unsigned BitJalr = 1;
  localparam int unsigned BitLui  = 2;
  localparam int unsigned BitAuipc = 3;
  localparam int unsigned BitB    = 4;
  localparam int unsigned BitR    = 5;
  localparam int unsigned BitS    = 6;
  localparam int unsigned BitIAlu = 7;
  localparam int unsigned BitLoad = 8;
  localparam int unsigned BitCsr  = 9;

`ifdef CTRL_CSR_SUPPORT_EN
  localparam logic [9:0] ClassMask = 10'h3ff;
`else
  localparam logic [9:0] ClassMask = 10'h1ff;
`endif
  localparam logic [CODE_W-1:0] LegalMask = CODE_W'(ClassMask);

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;

  logic code_onehot, code_legal, active, mem_cls;
  logic is_j, is_jalr, is_lui, is_auipc, is_b, is_s, is_ialu, is_load;

  assign code_onehot = (code_q != '0) && ((code_q & (code_q - CODE_W'(1))) == '0);
  // Legal means one-hot on a class this build actually executes.
  assign code_legal  = code_onehot && ((code_q & ~LegalMask) == '0);

  assign is_j     = code_onehot & code_q[BitJ];
  assign is_jalr  = code_onehot & code_q[BitJalr];
  assign is_lui   = code_onehot & code_q[BitLui];
  assign is_auipc = code_onehot & code_q[BitAuipc];
  assign is_b     = code_onehot & code_q[BitB];
  assign is_s     = code_onehot & code_q[BitS];
  assign is_ialu  = code_onehot & code_q[BitIAlu];
  assign is_load  = code_onehot & code_q[BitLoad];
  assign mem_cls  = is_s | is_load;

  assign active = (state_q == StDecode) || (state_q == StExec) ||
                  (state_q == StMem)    || (state_q == StWb);

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
    bus.busy    = (state_q != StIdle);
    bus.alu_sel_A = active & (is_j | is_auipc);
    bus.alu_sel_B = active & (is_j | is_jalr | is_lui | is_auipc | is_s | is_ialu | is_load);
    bus.pc_load = 1'b0;
    bus.rf_we   = 1'b0;
    bus.mem_rd  = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.done    = 1'b0;
    bus.illegal = 1'b0;
    bus.timeout = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          code_d  = bus.CODE;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = code_legal ? StExec : StTrap;
      end
      StExec: begin
        bus.pc_load = is_j | is_jalr | (is_b & bus.branch_taken);
        if (mem_cls) begin
          cnt_d   = '0;
          state_d = StMem;
        end else if (is_b) begin
          bus.done = 1'b1;
          state_d  = StIdle;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        bus.mem_rd = is_load;
        bus.mem_wr = is_s;
        if (bus.mem_ready) begin
          if (is_load) begin
            state_d = StWb;
          end else begin
            bus.done = 1'b1;
            state_d  = StIdle;
          end
        end else begin
          cnt_d = cnt_q + WAIT_W'(1);
          if (cnt_d == WAIT_W'(MAX_WAIT)) begin
            state_d = StTrap;
          end
        end
      end
      StWb: begin
        bus.rf_we = 1'b1;
        bus.done  = 1'b1;
        state_d   = StIdle;
      end
      StTrap: begin
        bus.done = 1'b1;
        // Only a legal S/LOAD can reach TRAP from MEM; anything else is a decode error.
        if (mem_cls) begin
          bus.timeout = 1'b1;
        end else begin
          bus.illegal = 1'b1;
        end
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected per-instruction outcomes are queued at issue
// and compared when the sequencer signals done.
module tb_control_sequencer;

  localparam int unsigned CodeW   = 10;
  localparam int unsigned MaxWait = 15;

  localparam logic [9:0] CJ = 10'b0000000001, CJalr = 10'b0000000010, CLui = 10'b0000000100;
  localparam logic [9:0] CAuipc = 10'b0000001000, CB = 10'b0000010000, CR = 10'b0000100000;
  localparam logic [9:0] CS = 10'b0001000000, CIAlu = 10'b0010000000, CLoad = 10'b0100000000;
  localparam logic [9:0] CCsr = 10'b1000000000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  control_sequencer_if #(.CODE_W(CodeW)) bus ();

  control_sequencer #(
    .CODE_W  (CodeW),
    .WAIT_W  (4),
    .MAX_WAIT(MaxWait)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int lat;
    int rf_we;
    int mem_rd;
    int mem_wr;
    int pc_load;
    int illegal;
    int timeout;
    int sel_a;
    int sel_b;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [9:0] code, input bit br, input int nwait);
    exp_t e;
    logic [9:0] mask;
    e = '{default: 0};
`ifdef CTRL_CSR_SUPPORT_EN
    mask = 10'h3ff;
`else
    mask = 10'h1ff;
`endif
    if (!$onehot(code) || ((code & ~mask) != 10'h0)) begin
      e.lat     = 2;
      e.illegal = 1;
      return e;
    end
    e.sel_a = ((code & (CJ | CAuipc)) != 10'h0) ? 1 : 0;
    e.sel_b = ((code & (CJ | CJalr | CLui | CAuipc | CS | CIAlu | CLoad)) != 10'h0) ? 1 : 0;
    if (code == CB) begin
      e.lat     = 2;
      e.pc_load = br ? 1 : 0;
    end else if (code == CS || code == CLoad) begin
      if (nwait >= int'(MaxWait)) begin
        e.lat     = 3 + int'(MaxWait);
        e.timeout = 1;
        if (code == CLoad) e.mem_rd = int'(MaxWait);
        else e.mem_wr = int'(MaxWait);
      end else if (code == CLoad) begin
        e.lat    = 4 + nwait;
        e.mem_rd = nwait + 1;
        e.rf_we  = 1;
      end else begin
        e.lat    = 3 + nwait;
        e.mem_wr = nwait + 1;
      end
    end else begin
      e.lat     = 3;
      e.rf_we   = 1;
      e.pc_load = (code == CJ || code == CJalr) ? 1 : 0;
    end
    return e;
  endfunction

  // Monitor: accumulate per-instruction activity, compare against the scoreboard on done.
  int   m_lat, m_rf, m_rd, m_wr, m_pc, m_ill, m_to, m_sa, m_sb;
  exp_t m_e;

  task automatic mon_clear();
    m_lat = 0; m_rf = 0; m_rd = 0; m_wr = 0; m_pc = 0;
    m_ill = 0; m_to = 0; m_sa = 0; m_sb = 0;
  endtask

  initial begin
    mon_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_clear();
      end else if (bus.busy) begin
        m_lat++;
        m_rf  += int'(bus.rf_we);
        m_rd  += int'(bus.mem_rd);
        m_wr  += int'(bus.mem_wr);
        m_pc  += int'(bus.pc_load);
        m_ill += int'(bus.illegal);
        m_to  += int'(bus.timeout);
        if (bus.alu_sel_A) m_sa = 1;
        if (bus.alu_sel_B) m_sb = 1;
        if (bus.done) begin
          if (sb_q.size() == 0) begin
            check_val("unexpected_done", 1, 0);
          end else begin
            m_e = sb_q.pop_front();
            check_val("latency", m_lat, m_e.lat);
            check_val("rf_we", m_rf, m_e.rf_we);
            check_val("mem_rd", m_rd, m_e.mem_rd);
            check_val("mem_wr", m_wr, m_e.mem_wr);
            check_val("pc_load", m_pc, m_e.pc_load);
            check_val("illegal", m_ill, m_e.illegal);
            check_val("timeout", m_to, m_e.timeout);
            check_val("alu_sel_A", m_sa, m_e.sel_a);
            check_val("alu_sel_B", m_sb, m_e.sel_b);
          end
          mon_clear();
        end
      end
    end
  end

  task automatic run_txn(input logic [9:0] code, input bit br, input int nwait, input bit noise,
                         input bit rel_rst);
    int mem_idx;
    bit fin;
    mem_idx = 0;
    fin     = 1'b0;
    @(posedge clk); #1;
    if (rel_rst) rst_n = 1'b1;
    bus.start        = 1'b1;
    bus.CODE         = code;
    bus.branch_taken = br;
    bus.mem_ready    = 1'b0;
    sb_q.push_back(model(code, br, nwait));
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (i == 0) check_val("accept", int'(bus.busy), 1);
      // Extra start pulses while busy must be ignored.
      bus.start = noise;
      if (noise) bus.CODE = 10'($urandom);
      if (bus.mem_rd || bus.mem_wr) mem_idx++;
      bus.mem_ready = (bus.mem_rd || bus.mem_wr) && (mem_idx == nwait + 1);
      if (!bus.busy) begin
        fin = 1'b1;
        break;
      end
    end
    bus.start     = 1'b0;
    bus.mem_ready = 1'b0;
    if (!fin) check_val("txn_bound", 0, 1);
  endtask

  task automatic reset_mid_mem();
    bit hit;
    hit = 1'b0;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.CODE      = CS;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.mem_wr) begin
        hit = 1'b1;
        break;
      end
    end
    check_val("reach_mem", int'(hit), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_mem_wr", int'(bus.mem_wr), 0);
    check_val("rst_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] rc;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.CODE         = '0;
    bus.branch_taken = 1'b0;
    bus.mem_ready    = 1'b0;
    #1;
    check_val("reset_outputs", int'({bus.busy, bus.alu_sel_A, bus.alu_sel_B, bus.pc_load,
                                     bus.rf_we, bus.mem_rd, bus.mem_wr, bus.done,
                                     bus.illegal, bus.timeout}), 0);
    bus.start = 1'b1;
    bus.CODE  = CR;
    @(posedge clk); #1;
    check_val("reset_ignores_start", int'(bus.busy), 0);
    bus.start = 1'b0;

    // Reset release and start share the same edge.
    run_txn(CR, 1'b0, 0, 1'b0, 1'b1);
    run_txn(CIAlu, 1'b0, 0, 1'b1, 1'b0);
    run_txn(CJ, 1'b0, 0, 1'b0, 1'b0);
    run_txn(CJalr, 1'b1, 0, 1'b0, 1'b0);
    run_txn(CLui, 1'b0, 0, 1'b1, 1'b0);
    run_txn(CAuipc, 1'b0, 0, 1'b0, 1'b0);
    run_txn(CB, 1'b1, 0, 1'b0, 1'b0);
    run_txn(CB, 1'b0, 0, 1'b1, 1'b0);
    run_txn(CS, 1'b0, 0, 1'b0, 1'b0);
    run_txn(CS, 1'b0, 2, 1'b1, 1'b0);
    run_txn(CLoad, 1'b0, 2, 1'b0, 1'b0);
    run_txn(CLoad, 1'b0, 0, 1'b0, 1'b0);
    run_txn(CLoad, 1'b0, 14, 1'b0, 1'b0);
    run_txn(CLoad, 1'b0, 15, 1'b0, 1'b0);
    run_txn(CS, 1'b0, 99, 1'b1, 1'b0);
    run_txn(10'b0000000011, 1'b0, 0, 1'b0, 1'b0);
    run_txn(10'b0000000000, 1'b0, 0, 1'b0, 1'b0);
    run_txn(CCsr, 1'b0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      rc = 10'(1) << $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) rc = 10'($urandom);
      run_txn(rc, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)), 1'b0);
    end

    reset_mid_mem();
    sb_q.delete();
    run_txn(CR, 1'b0, 0, 1'b0, 1'b1);
    run_txn(CLoad, 1'b0, 1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_val("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
